// File: rtl/matrix_addsub_seq.sv
// matrix_addsub_seq
// Sequential element-wise add/subtract engine for N x N signed int8 matrices.
// Both operands and the operation are captured when a start request is
// accepted. The engine then produces one saturated result element per clock,
// tracks how many elements saturated, and pulses done for one cycle when the
// whole result matrix is valid.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   rst      asynchronous active-high reset
//   start    one-cycle request, only sampled while idle
//   op       0 = A+B, 1 = A-B, captured together with start
//   mat_a    operand A, row-major, element i at [i*W +: W]
//   mat_b    operand B, same packing as mat_a
//   mat_r    result matrix, same packing as mat_a
//   busy     high from the accepting edge until the done cycle is left
//   done     one-cycle pulse once mat_r is complete
//   ovf      sticky: some element of the current operation saturated
//   ovf_cnt  number of saturated elements in the current operation
module matrix_addsub_seq #(
  parameter int N  = 5,
  parameter int W  = 8,
  parameter int CW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [N*N*W-1:0]  mat_a,
  input  logic [N*N*W-1:0]  mat_b,
  output logic [N*N*W-1:0]  mat_r,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [CW-1:0]     ovf_cnt
);

  localparam int NE = N * N;
  localparam int MW = NE * W;
  localparam logic [CW-1:0] LAST_IDX = CW'(NE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [MW-1:0]    a_reg;
  logic [MW-1:0]    b_reg;
  logic             op_reg;
  logic [CW-1:0]    idx;

  logic [W-1:0]     a_elem;
  logic [W-1:0]     b_elem;
  logic signed [W:0] sum;
  logic             sat;
  logic [W-1:0]     res_elem;

  // Element arithmetic is done one bit wider than the operands, which is
  // exactly wide enough for any sum or difference of two W-bit values. The
  // subtraction works on the raw B operand, so -128 needs no negation and
  // cases such as (-1) - (-128) = 127 come out exact. Saturation is detected
  // when the extra sign bit disagrees with the W-bit result's sign bit.
  always_comb begin
    a_elem   = a_reg[int'(idx)*W +: W];
    b_elem   = b_reg[int'(idx)*W +: W];
    if (op_reg) begin
      sum = $signed({a_elem[W-1], a_elem}) - $signed({b_elem[W-1], b_elem});
    end else begin
      sum = $signed({a_elem[W-1], a_elem}) + $signed({b_elem[W-1], b_elem});
    end
    sat      = (sum[W] != sum[W-1]);
    res_elem = sum[W-1:0];
    if (sat) begin
      res_elem = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A start seen outside IDLE is simply dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Datapath: capture operands on acceptance, then write one result element
  // per clock. The previous result stays visible in mat_r until each element
  // is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= 1'b0;
      idx     <= '0;
      mat_r   <= '0;
      ovf     <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= mat_a;
            b_reg   <= mat_b;
            op_reg  <= op;
            idx     <= '0;
            ovf     <= 1'b0;
            ovf_cnt <= '0;
          end
        end
        RUN: begin
          mat_r[int'(idx)*W +: W] <= res_elem;
          if (sat) begin
            ovf     <= 1'b1;
            ovf_cnt <= ovf_cnt + CW'(1);
          end
          idx <= idx + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// tb_matrix_addsub_seq
// Self-checking bench for matrix_addsub_seq. Expected results come from an
// integer-arithmetic model of the element rules; operands are directed
// corner patterns plus $urandom matrices.
module tb_matrix_addsub_seq;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int CW = 5;
  localparam int NE = N * N;
  localparam int NW = NE * W;

  logic          clk;
  logic          rst;
  logic          start;
  logic          op;
  logic [NW-1:0] mat_a;
  logic [NW-1:0] mat_b;
  logic [NW-1:0] mat_r;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [CW-1:0] ovf_cnt;

  int errors = 0;
  int checks = 0;

  matrix_addsub_seq #(.N(N), .W(W), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .mat_a   (mat_a),
    .mat_b   (mat_b),
    .mat_r   (mat_r),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .ovf_cnt (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: each element is the plain integer sum or difference,
  // clamped to the int8 range; every clamp counts one saturation.
  function automatic logic [NW-1:0] model_result(input logic [NW-1:0] a,
                                                 input logic [NW-1:0] b,
                                                 input logic o,
                                                 output int sat_cnt);
    logic [NW-1:0]     r;
    logic signed [7:0] ea;
    logic signed [7:0] eb;
    int                s;
    logic [31:0]       su;
    r       = '0;
    sat_cnt = 0;
    for (int i = 0; i < NE; i++) begin
      ea = a[i*W +: W];
      eb = b[i*W +: W];
      s  = o ? (int'(ea) - int'(eb)) : (int'(ea) + int'(eb));
      if (s > 127) begin
        s = 127;
        sat_cnt++;
      end else if (s < -128) begin
        s = -128;
        sat_cnt++;
      end
      su = s;
      r[i*W +: W] = su[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] rand_mat();
    logic [NW-1:0] r;
    logic [31:0]   u;
    for (int i = 0; i < NE; i++) begin
      u = $urandom;
      r[i*W +: W] = u[W-1:0];
    end
    return r;
  endfunction

  function automatic logic [NW-1:0] fill_mat(input logic [W-1:0] v);
    logic [NW-1:0] r;
    for (int i = 0; i < NE; i++) r[i*W +: W] = v;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [NW-1:0] observed,
                             input logic [NW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one request for a single clock, then scramble the operand inputs
  // so that only the captured copy can produce the right result.
  task automatic applyStimulus(input logic [NW-1:0] a, input logic [NW-1:0] b,
                               input logic o);
    @(negedge clk);
    mat_a = a;
    mat_b = b;
    op    = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mat_a = rand_mat();
    mat_b = rand_mat();
    op    = ~o;
  endtask

  // Full operation: request, wait (bounded) for done, check result, latency,
  // flags and the single-cycle done pulse. Optional extra start pulses are
  // fired in the middle of RUN and during the DONE cycle.
  task automatic run_op(input string tag, input logic [NW-1:0] a,
                        input logic [NW-1:0] b, input logic o,
                        input int inj_run, input bit inj_done);
    logic [NW-1:0] exp_r;
    int            exp_cnt;
    int            cyc;
    exp_r = model_result(a, b, o, exp_cnt);
    applyStimulus(a, b, o);
    checkOutput({tag, "_busy_start"}, NW'(busy), NW'(1'b1));
    checkOutput({tag, "_cnt_clear"}, NW'(ovf_cnt), NW'(0));
    cyc = 0;
    while (cyc < 100 && done !== 1'b1) begin
      if (cyc == inj_run) begin
        start = 1'b1;
        mat_a = rand_mat();
        mat_b = rand_mat();
        op    = ~o;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    checkOutput({tag, "_latency"}, NW'(cyc), NW'(NE));
    checkOutput({tag, "_busy_done"}, NW'(busy), NW'(1'b1));
    checkOutput({tag, "_mat_r"}, mat_r, exp_r);
    checkOutput({tag, "_ovf"}, NW'(ovf), NW'(exp_cnt != 0));
    checkOutput({tag, "_ovf_cnt"}, NW'(ovf_cnt), NW'(exp_cnt));
    if (inj_done) begin
      start = 1'b1;
      mat_a = rand_mat();
      mat_b = rand_mat();
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_done_pulse"}, NW'(done), NW'(1'b0));
    checkOutput({tag, "_busy_idle"}, NW'(busy), NW'(1'b0));
    if (inj_done) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_ignored_busy"}, NW'(busy), NW'(1'b0));
      checkOutput({tag, "_ignored_mat_r"}, mat_r, exp_r);
    end
  endtask

  initial begin
    logic [NW-1:0] a;
    logic [NW-1:0] b;
    logic [31:0]   u;

    rst   = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    mat_a = '0;
    mat_b = '0;
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset then idle: nothing moves while start stays low.
    $display("[TB] reset and idle");
    for (int i = 0; i < 10; i++) begin
      mat_a = rand_mat();
      @(posedge clk);
      #1;
      checkOutput("idle_busy", NW'(busy), NW'(1'b0));
    end
    checkOutput("idle_mat_r", mat_r, '0);
    checkOutput("idle_done", NW'(done), NW'(1'b0));
    checkOutput("idle_ovf", NW'(ovf), NW'(1'b0));
    checkOutput("idle_ovf_cnt", NW'(ovf_cnt), NW'(0));

    // Plain add: A[i] = i, B[i] = 2i gives 3i everywhere.
    $display("[TB] plain add");
    for (int i = 0; i < NE; i++) begin
      a[i*W +: W] = 8'(i);
      b[i*W +: W] = 8'(2 * i);
    end
    run_op("plain_add", a, b, 1'b0, -1, 1'b0);
    checkOutput("plain_add_elem24", NW'(mat_r[24*W +: W]), NW'(8'd72));

    // Saturating add: positive clamp on the first ten elements only.
    $display("[TB] saturating add");
    a = fill_mat(8'd100);
    for (int i = 0; i < NE; i++) begin
      b[i*W +: W] = (i < 10) ? 8'd50 : ((i < 20) ? 8'hCE : 8'd27);
    end
    run_op("sat_add", a, b, 1'b0, -1, 1'b0);
    checkOutput("sat_add_elem0", NW'(mat_r[0 +: W]), NW'(8'h7F));
    checkOutput("sat_add_elem10", NW'(mat_r[10*W +: W]), NW'(8'd50));
    checkOutput("sat_add_elem20", NW'(mat_r[20*W +: W]), NW'(8'd127));
    checkOutput("sat_add_count", NW'(ovf_cnt), NW'(10));

    // Negative clamp on every element: the counter reaches its maximum use.
    $display("[TB] negative saturation");
    run_op("neg_sat", fill_mat(8'h9C), fill_mat(8'h9C), 1'b0, -1, 1'b0);
    checkOutput("neg_sat_elem0", NW'(mat_r[0 +: W]), NW'(8'h80));
    checkOutput("neg_sat_count", NW'(ovf_cnt), NW'(25));

    // Subtraction corners.
    $display("[TB] subtract corners");
    a = '0;
    b = '0;
    a[0*W +: W] = 8'hFF;  b[0*W +: W] = 8'h80;
    a[1*W +: W] = 8'h00;  b[1*W +: W] = 8'h80;
    a[2*W +: W] = 8'h80;  b[2*W +: W] = 8'h01;
    a[3*W +: W] = 8'h05;  b[3*W +: W] = 8'h07;
    run_op("sub_corner", a, b, 1'b1, -1, 1'b0);
    checkOutput("sub_m1_m128", NW'(mat_r[0*W +: W]), NW'(8'h7F));
    checkOutput("sub_0_m128", NW'(mat_r[1*W +: W]), NW'(8'h7F));
    checkOutput("sub_m128_1", NW'(mat_r[2*W +: W]), NW'(8'h80));
    checkOutput("sub_5_7", NW'(mat_r[3*W +: W]), NW'(8'hFE));
    checkOutput("sub_count", NW'(ovf_cnt), NW'(2));

    // Start while busy (RUN cycle 5 and the DONE cycle) is ignored; the next
    // start from IDLE runs normally with a fresh count.
    $display("[TB] start while busy");
    run_op("busy_start", rand_mat(), rand_mat(), 1'b1, 5, 1'b1);
    for (int i = 0; i < NE; i++) begin
      b[i*W +: W] = (i < 10) ? 8'd50 : ((i < 20) ? 8'hCE : 8'd27);
    end
    run_op("after_busy", fill_mat(8'd100), b, 1'b0, -1, 1'b0);

    // Random operations, back to back.
    $display("[TB] random operations");
    for (int k = 0; k < 6; k++) begin
      u = $urandom;
      run_op("random", rand_mat(), rand_mat(), u[0], -1, 1'b0);
    end

    // Asynchronous reset in the middle of RUN.
    $display("[TB] reset mid-run");
    applyStimulus(fill_mat(8'd100), fill_mat(8'd100), 1'b0);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("midrun_ovf_before", NW'(ovf), NW'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrun_mat_r", mat_r, '0);
    checkOutput("midrun_busy", NW'(busy), NW'(1'b0));
    checkOutput("midrun_done", NW'(done), NW'(1'b0));
    checkOutput("midrun_ovf", NW'(ovf), NW'(1'b0));
    checkOutput("midrun_ovf_cnt", NW'(ovf_cnt), NW'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("midrun_hold_done", NW'(done), NW'(1'b0));
    end
    @(negedge clk);
    rst = 1'b0;
    run_op("after_reset", rand_mat(), rand_mat(), 1'b1, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
